snake_game_ctrl: RTL and testbench

- Game sequencer for the Crazy-Snake VGA datapath.
- Owns the game state machine (idle/run/pause/over) and the move-tick divider.
- Commits direction requests with reversal rejection and decides fruit-eat and self-collision after each move.
- Drives move/grow/fruit-reload strobes and the 4-digit BCD score consumed by the graphics block and score display.

---
 rtl/snake_game_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : snake_game_ctrl
// Description : Crazy-Snake game sequencer: game FSM, move-tick divider,
//               direction commit, eat/collision decision and BCD score.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_game_ctrl #(
    parameter int TICK_DIV = 8000000,
    parameter int MAX_SEG  = 20,
    parameter int LEN_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_pulse,
    input  logic             pause_pulse,
    input  logic             dir_valid,
    input  logic [3:0]       dir_req,
    input  logic [9:0]       head_x,
    input  logic [9:0]       head_y,
    input  logic [9:0]       fruit_x,
    input  logic [9:0]       fruit_y,
    input  logic             self_hit,
    output logic             init_pulse,
    output logic             move_tick,
    output logic [3:0]       move_dir,
    output logic             grow_pulse,
    output logic             fruit_load,
    output logic [LEN_W-1:0] seg_count,
    output logic [3:0]       score1,
    output logic [3:0]       score2,
    output logic [3:0]       score3,
    output logic [3:0]       score4,
    output logic             paused,
    output logic             game_over
);

    localparam int               CNT_W       = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [LEN_W-1:0] c_MAX_SEG   = LEN_W'(MAX_SEG);
    localparam logic [1:0]       c_DIR_RIGHT = 2'd3;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RUN   = 3'd1;
    localparam logic [2:0] c_ST_EVAL  = 3'd2;
    localparam logic [2:0] c_ST_PAUSE = 3'd3;
    localparam logic [2:0] c_ST_OVER  = 3'd4;

    logic [2:0]       r_state,     w_state;
    logic [CNT_W-1:0] r_tickCnt,   w_tickCnt;
    logic [1:0]       r_curDir,    w_curDir;
    logic [1:0]       r_pendDir,   w_pendDir;
    logic [LEN_W-1:0] r_segCount,  w_segCount;
    logic [15:0]      r_score,     w_score;
    logic             r_initPulse, w_initPulse;
    logic             r_moveTick,  w_moveTick;
    logic             r_growPulse, w_growPulse;
    logic             r_fruitLoad, w_fruitLoad;
    logic             w_dirOk;
    logic             w_eat;

    // Four-digit BCD increment; an all-nines value rolls over to zero.
    function automatic logic [15:0] bcdInc(input logic [15:0] value);
        logic [15:0] w_val;
        logic        w_carry;
        w_val   = value;
        w_carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (w_val[i*4 +: 4] == 4'd9) begin
                    w_val[i*4 +: 4] = 4'd0;
                end else begin
                    w_val[i*4 +: 4] = w_val[i*4 +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
        end
        return w_val;
    endfunction

    // Reversal is checked against the direction actually travelled, not the pending one.
    assign w_dirOk = dir_valid && (dir_req <= 4'd3) && (dir_req[1:0] != (r_curDir ^ 2'b01));
    assign w_eat   = (head_x == fruit_x) && (head_y == fruit_y);

    always_comb begin
        w_state     = r_state;
        w_tickCnt   = r_tickCnt;
        w_curDir    = r_curDir;
        w_pendDir   = r_pendDir;
        w_segCount  = r_segCount;
        w_score     = r_score;
        w_initPulse = 1'b0;
        w_moveTick  = 1'b0;
        w_growPulse = 1'b0;
        w_fruitLoad = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_OVER: begin
                if (start_pulse) begin
                    w_state     = c_ST_RUN;
                    w_initPulse = 1'b1;
                    w_score     = 16'h0000;
                    w_segCount  = '0;
                    w_curDir    = c_DIR_RIGHT;
                    w_pendDir   = c_DIR_RIGHT;
                    w_tickCnt   = '0;
                end
            end
            c_ST_RUN: begin
                if (w_dirOk) w_pendDir = dir_req[1:0];
                // A pause on the tick cycle holds the counter so the tick fires right after resume.
                if (pause_pulse) begin
                    w_state = c_ST_PAUSE;
                end else if (r_tickCnt == c_TICK_LAST) begin
                    w_tickCnt  = '0;
                    w_curDir   = r_pendDir;
                    w_moveTick = 1'b1;
                    w_state    = c_ST_EVAL;
                end else begin
                    w_tickCnt = r_tickCnt + CNT_W'(1);
                end
            end
            c_ST_EVAL: begin
                if (w_dirOk) w_pendDir = dir_req[1:0];
                w_tickCnt = r_tickCnt + CNT_W'(1);
                if (self_hit) begin
                    w_state = c_ST_OVER;
                end else begin
                    if (w_eat) begin
                        w_fruitLoad = 1'b1;
                        w_score     = bcdInc(r_score);
                        if (r_segCount < c_MAX_SEG) begin
                            w_growPulse = 1'b1;
                            w_segCount  = r_segCount + LEN_W'(1);
                        end
                    end
                    w_state = pause_pulse ? c_ST_PAUSE : c_ST_RUN;
                end
            end
            c_ST_PAUSE: begin
                if (pause_pulse) w_state = c_ST_RUN;
            end
            default: w_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_tickCnt   <= '0;
            r_curDir    <= c_DIR_RIGHT;
            r_pendDir   <= c_DIR_RIGHT;
            r_segCount  <= '0;
            r_score     <= 16'h0000;
            r_initPulse <= 1'b0;
            r_moveTick  <= 1'b0;
            r_growPulse <= 1'b0;
            r_fruitLoad <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_tickCnt   <= w_tickCnt;
            r_curDir    <= w_curDir;
            r_pendDir   <= w_pendDir;
            r_segCount  <= w_segCount;
            r_score     <= w_score;
            r_initPulse <= w_initPulse;
            r_moveTick  <= w_moveTick;
            r_growPulse <= w_growPulse;
            r_fruitLoad <= w_fruitLoad;
        end
    end

    assign init_pulse = r_initPulse;
    assign move_tick  = r_moveTick;
    assign move_dir   = {2'b00, r_curDir};
    assign grow_pulse = r_growPulse;
    assign fruit_load = r_fruitLoad;
    assign seg_count  = r_segCount;
    assign score1     = r_score[3:0];
    assign score2     = r_score[7:4];
    assign score3     = r_score[11:8];
    assign score4     = r_score[15:12];
    assign paused     = (r_state == c_ST_PAUSE);
    assign game_over  = (r_state == c_ST_OVER);

endmodule
`default_nettype wire

// File: tb/tb_snake_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_game_ctrl
// Description : Self-checking bench for snake_game_ctrl against a game model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_game_ctrl;

    localparam int TD    = 4;
    localparam int MAXS  = 3;
    localparam int LEN_W = 5;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_OVER  = 3;

    logic             clk = 1'b0;
    logic             reset, start_pulse, pause_pulse, dir_valid, self_hit;
    logic [3:0]       dir_req;
    logic [9:0]       head_x, head_y, fruit_x, fruit_y;
    logic             init_pulse, move_tick, grow_pulse, fruit_load, paused, game_over;
    logic [3:0]       move_dir, score1, score2, score3, score4;
    logic [LEN_W-1:0] seg_count;

    int nVec = 0;
    int nMis = 0;

    snake_game_ctrl #(.TICK_DIV(TD), .MAX_SEG(MAXS), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start_pulse(start_pulse), .pause_pulse(pause_pulse),
        .dir_valid(dir_valid), .dir_req(dir_req), .head_x(head_x), .head_y(head_y),
        .fruit_x(fruit_x), .fruit_y(fruit_y), .self_hit(self_hit),
        .init_pulse(init_pulse), .move_tick(move_tick), .move_dir(move_dir),
        .grow_pulse(grow_pulse), .fruit_load(fruit_load), .seg_count(seg_count),
        .score1(score1), .score2(score2), .score3(score3), .score4(score4),
        .paused(paused), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nMis++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int toBcd(input int s);
        return (((s / 1000) % 10) << 12) | (((s / 100) % 10) << 8) | (((s / 10) % 10) << 4) | (s % 10);
    endfunction

    // Game model: mode plus a flag marking the single evaluation cycle after a move.
    bit mValid = 1'b0;
    int mMode, mCnt, mCur, mPend, mSeg, mScore;
    bit mEval, mAcc, mEatNow;
    bit eInit, eMove, eGrow, eFruit;

    always @(posedge clk) begin
        eInit  = 1'b0;
        eMove  = 1'b0;
        eGrow  = 1'b0;
        eFruit = 1'b0;
        if (reset) begin
            mValid = 1'b1;
            mMode  = M_IDLE;
            mEval  = 1'b0;
            mCnt   = 0;
            mCur   = 3;
            mPend  = 3;
            mSeg   = 0;
            mScore = 0;
        end else if (mValid) begin
            mAcc    = (mMode == M_RUN) && dir_valid && (int'(dir_req) < 4) && (int'(dir_req) != (mCur ^ 1));
            mEatNow = (head_x == fruit_x) && (head_y == fruit_y);
            if (mMode == M_IDLE || mMode == M_OVER) begin
                if (start_pulse) begin
                    mMode = M_RUN; eInit = 1'b1; mScore = 0; mSeg = 0;
                    mCur = 3; mPend = 3; mCnt = 0;
                end
            end else if (mMode == M_RUN && mEval) begin
                mEval = 1'b0;
                mCnt++;
                if (self_hit) begin
                    mMode = M_OVER;
                end else begin
                    if (mEatNow) begin
                        eFruit = 1'b1;
                        mScore = (mScore + 1) % 10000;
                        if (mSeg < MAXS) begin mSeg++; eGrow = 1'b1; end
                    end
                    if (pause_pulse) mMode = M_PAUSE;
                end
            end else if (mMode == M_RUN) begin
                if (pause_pulse) mMode = M_PAUSE;
                else if (mCnt == TD - 1) begin
                    mCnt = 0; mCur = mPend; eMove = 1'b1; mEval = 1'b1;
                end else mCnt++;
            end else if (mMode == M_PAUSE) begin
                if (pause_pulse) mMode = M_RUN;
            end
            if (mAcc) mPend = int'(dir_req);
        end
    end

    always @(negedge clk) begin
        if (mValid) begin
            chk("cmp_init", init_pulse, eInit);
            chk("cmp_move", move_tick, eMove);
            if (eMove) chk("cmp_dir", move_dir, mCur);
            chk("cmp_grow", grow_pulse, eGrow);
            chk("cmp_fruit", fruit_load, eFruit);
            chk("cmp_seg", seg_count, mSeg);
            chk("cmp_score", {score4, score3, score2, score1}, toBcd(mScore));
            chk("cmp_paused", paused, mMode == M_PAUSE);
            chk("cmp_over", game_over, mMode == M_OVER);
        end
    end

    task automatic waitMove(output bit ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!move_tick && n < 8 * TD);
        ok = move_tick;
        if (!ok) begin
            nVec++;
            nMis++;
            $display("FAIL move_timeout: no move_tick within %0d cycles", n);
        end
    endtask

    task automatic setEat(input bit e);
        fruit_x = 10'd152;
        fruit_y = 10'd152;
        head_x  = e ? 10'd152 : 10'd153;
        head_y  = 10'd152;
    endtask

    task automatic eatOnce(output bit g, output bit f);
        bit ok;
        waitMove(ok);
        setEat(1'b1);
        @(negedge clk);
        g = grow_pulse;
        f = fruit_load;
        setEat(1'b0);
    endtask

    initial begin
        logic [12:0] mv;
        bit ok, g, f, anyMove, allPaused;
        reset = 1'b1; start_pulse = 1'b0; pause_pulse = 1'b0; dir_valid = 1'b0;
        dir_req = 4'd0; self_hit = 1'b0;
        setEat(1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_score", {score4, score3, score2, score1}, 0);
        chk("rst_seg", seg_count, 0);
        chk("rst_paused", paused, 0);
        chk("rst_over", game_over, 0);
        chk("rst_init", init_pulse, 0);
        chk("rst_dir", move_dir, 3);
        repeat (2) @(negedge clk);

        start_pulse = 1'b1; @(negedge clk); start_pulse = 1'b0;
        chk("start_init", init_pulse, 1);
        mv = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            mv[k] = move_tick;
        end
        chk("tick_spacing", mv, 13'b1_0001_0001_0000);
        chk("tick_dir", move_dir, 3);

        dir_valid = 1'b1; dir_req = 4'd2; @(negedge clk);
        dir_req = 4'd0; @(negedge clk); dir_valid = 1'b0;
        waitMove(ok);
        chk("turn_up", move_dir, 0);
        dir_valid = 1'b1; dir_req = 4'd1; @(negedge clk); dir_valid = 1'b0;
        waitMove(ok);
        chk("reverse_drop", move_dir, 0);

        for (int i = 1; i <= 10; i++) begin
            eatOnce(g, f);
            if (i == 1) begin
                chk("eat1_grow", g, 1);
                chk("eat1_fruit", f, 1);
                chk("eat1_score", {score4, score3, score2, score1}, 16'h0001);
                chk("eat1_seg", seg_count, 1);
            end
            if (i == 4) begin
                chk("sat_grow", g, 0);
                chk("sat_fruit", f, 1);
                chk("sat_seg", seg_count, 3);
            end
        end
        chk("score_carry", {score4, score3, score2, score1}, 16'h0010);

        waitMove(ok);
        setEat(1'b1); self_hit = 1'b1; @(negedge clk);
        self_hit = 1'b0; setEat(1'b0);
        chk("hit_over", game_over, 1);
        chk("hit_grow", grow_pulse, 0);
        chk("hit_score", {score4, score3, score2, score1}, 16'h0010);
        repeat (3) @(negedge clk);
        chk("over_hold", game_over, 1);
        start_pulse = 1'b1; @(negedge clk); start_pulse = 1'b0;
        chk("restart_init", init_pulse, 1);
        chk("restart_score", {score4, score3, score2, score1}, 0);
        chk("restart_over", game_over, 0);

        repeat (3) @(negedge clk);
        pause_pulse = 1'b1; @(negedge clk); pause_pulse = 1'b0;
        chk("pause_no_move", move_tick, 0);
        chk("pause_flag", paused, 1);
        anyMove = 1'b0; allPaused = 1'b1;
        repeat (100) begin
            @(negedge clk);
            anyMove   |= move_tick;
            allPaused &= paused;
        end
        chk("pause_frozen", anyMove, 0);
        chk("pause_hold", allPaused, 1);
        pause_pulse = 1'b1; @(negedge clk); pause_pulse = 1'b0;
        chk("resume_flag", paused, 0);
        chk("resume_early", move_tick, 0);
        @(negedge clk);
        chk("resume_move", move_tick, 1);

        setEat(1'b1); reset = 1'b1; @(negedge clk);
        reset = 1'b0; setEat(1'b0);
        chk("rstev_grow", grow_pulse, 0);
        chk("rstev_fruit", fruit_load, 0);
        chk("rstev_score", {score4, score3, score2, score1}, 0);
        chk("rstev_seg", seg_count, 0);

        start_pulse = 1'b1; @(negedge clk); start_pulse = 1'b0;
        setEat(1'b1);
        for (int i = 0; i < 9999; i++) begin
            waitMove(ok);
            if (!ok) break;
        end
        @(negedge clk);
        chk("score_9999", {score4, score3, score2, score1}, 16'h9999);
        waitMove(ok);
        @(negedge clk);
        chk("score_wrap", {score4, score3, score2, score1}, 16'h0000);
        setEat(1'b0);

        repeat (3000) begin
            @(negedge clk);
            reset       = ($urandom_range(0, 199) == 0);
            start_pulse = ($urandom_range(0, 19) == 0);
            pause_pulse = ($urandom_range(0, 29) == 0);
            dir_valid   = ($urandom_range(0, 3) == 0);
            dir_req     = 4'($urandom_range(0, 15));
            self_hit    = ($urandom_range(0, 19) == 0);
            fruit_x     = 10'($urandom_range(0, 1023));
            fruit_y     = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 0) begin
                head_x = fruit_x;
                head_y = fruit_y;
            end else begin
                head_x = fruit_x ^ 10'($urandom_range(1, 3));
                head_y = fruit_y;
            end
        end
        reset = 1'b0; start_pulse = 1'b0; pause_pulse = 1'b0; dir_valid = 1'b0; self_hit = 1'b0;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire
